// File: rtl/seq_pkg.sv
// Shared definitions for the state sequencer and its downstream decode stage:
// FSM encoding, default legal range and the range-check helper.
package seq_pkg;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_HOLD = 2'd2
    } seq_fsm_e;

    localparam int unsigned DEF_MIN_STATE = 0;
    localparam int unsigned DEF_MAX_STATE = 15;

    // Inclusive range test; wide argument so a request one past the top code is seen as such.
    function automatic logic in_range(input int unsigned val,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/state_sequencer_dwell_counter.sv
// Down-counter that times how long each state code stays visible.
// expire_o flags the enabled cycle in which the count sits at zero.
module dwell_counter #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               reload_i,
    input  logic [DWELL_W-1:0] reload_val_i,
    input  logic               en_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (reload_i) begin
            count_d = reload_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = en_i && (count_q == '0);

endmodule

// File: rtl/state_sequencer.sv
// Generates the range-checked state code for the decode stage, stepping it up
// or down with a programmable dwell per value; out-of-range loads are flagged.
module state_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MIN_STATE = DEF_MIN_STATE,
    parameter int unsigned MAX_STATE = DEF_MAX_STATE,
    parameter int unsigned DWELL_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               hold_i,
    input  logic               dir_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               load_i,
    input  logic [WIDTH:0]     load_val_i,
    output logic [WIDTH-1:0]   state_o,
    output logic               state_valid_o,
    output logic               wrap_o,
    output logic               bound_err_o
);

    localparam logic [WIDTH-1:0] MIN_CODE = WIDTH'(MIN_STATE);
    localparam logic [WIDTH-1:0] MAX_CODE = WIDTH'(MAX_STATE);

    seq_fsm_e         fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic             valid_q;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic load_ok;
    logic load_bad;
    logic start_go;
    logic run_en;
    logic expire;

    assign load_ok  = load_i && in_range(32'(load_val_i), MIN_STATE, MAX_STATE);
    assign load_bad = load_i && !load_ok;
    assign start_go = (fsm_q == FSM_IDLE) && start_i && !stop_i;
    // Counting only happens in an undisturbed RUN cycle; any higher-priority event freezes it.
    assign run_en   = (fsm_q == FSM_RUN) && !stop_i && !hold_i && !load_ok;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reload_i     (load_ok || start_go || expire),
        .reload_val_i (dwell_i),
        .en_i         (run_en),
        .expire_o     (expire)
    );

    always_comb begin
        fsm_d = fsm_q;
        if (stop_i) begin
            fsm_d = FSM_IDLE;
        end else begin
            case (fsm_q)
                FSM_IDLE: if (start_i) fsm_d = FSM_RUN;
                FSM_RUN:  if (hold_i)  fsm_d = FSM_HOLD;
                FSM_HOLD: if (!hold_i) fsm_d = FSM_RUN;
                default:  fsm_d = FSM_IDLE;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (load_ok) begin
            state_d = load_val_i[WIDTH-1:0];
        end else if (expire) begin
            if (!dir_i) begin
                wrap_d  = (state_q == MAX_CODE);
                state_d = wrap_d ? MIN_CODE : state_q + 1'b1;
            end else begin
                wrap_d  = (state_q == MIN_CODE);
                state_d = wrap_d ? MAX_CODE : state_q - 1'b1;
            end
        end
    end

    // A rejected load in the same cycle as start still leaves the flag set.
    always_comb begin
        err_d = err_q;
        if (start_go) err_d = 1'b0;
        if (load_bad) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= FSM_IDLE;
            state_q <= MIN_CODE;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            valid_q <= (fsm_d != FSM_IDLE);
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign state_o       = state_q;
    assign state_valid_o = valid_q;
    assign wrap_o        = wrap_q;
    assign bound_err_o   = err_q;

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Upstream stage that generates the 4-bit `state` code consumed by the case-decode stage that produces `data`.
- Steps `state` through the legal range MIN_STATE..MAX_STATE, holding each value for a programmable dwell, in up or down direction.
- Supports synchronous load.
- Range-checks every load value and never presents an out-of-range code downstream. A request for 16 is rejected and flagged, not truncated.

Parameters:
- WIDTH, 4, width of state output; legal codes 0..2**WIDTH-1.
- MIN_STATE, 0, lowest legal state; wrap target when counting up.
- MAX_STATE, 15, highest legal state; wrap target when counting down; must be <= 2**WIDTH-1.
- DWELL_W, 4, width of the dwell counter and dwell input.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; IDLE->RUN.
- stop  in  1  pulse; any state -> IDLE.
- hold  in  1  level; freezes sequencing while high in RUN.
- dir  in  1  0 = count up, 1 = count down; sampled at each advance.
- dwell  in  DWELL_W  cycles per state minus 1; sampled on entry to each state value.
- load  in  1  pulse; request state <= load_val.
- load_val  in  WIDTH+1  requested state; extra MSB allows detecting 2**WIDTH.
- state  out  WIDTH  current state code to decode stage.
- state_valid  out  1  high in RUN/HOLD; decode stage ignores state when low.
- wrap  out  1  one-cycle pulse when state wraps at a boundary.
- bound_err  out  1  sticky; set by a rejected load; cleared by start or reset.

Behaviour:
- Reset (async, Reset_n=0) values:
  - state = MIN_STATE, state_valid = 0, wrap = 0, bound_err = 0.
  - FSM = IDLE, dwell counter = 0.
- FSM states and transitions:
  - IDLE: state_valid = 0, state frozen. start -> RUN, dwell counter loaded from dwell, bound_err cleared.
  - RUN: state_valid = 1. Dwell counter decrements each cycle. When it reaches 0, advance state and reload the counter from dwell.
    - hold=1 -> HOLD (same cycle, no advance).
  - HOLD: state_valid = 1, counter frozen. hold=0 -> RUN, resuming the remaining count.
  - stop from RUN or HOLD -> IDLE next cycle; state keeps its last value.
- Priority when events coincide: stop > load > hold > advance. start is ignored unless in IDLE.
- Advance:
  - dir=0: state+1. If state==MAX_STATE, go to MIN_STATE and pulse wrap.
  - dir=1: state-1. If state==MIN_STATE, go to MAX_STATE and pulse wrap.
- Load, accepted in any FSM state:
  - If MIN_STATE <= load_val <= MAX_STATE: state <= load_val[WIDTH-1:0] next cycle, dwell counter reloaded, wrap = 0.
  - Otherwise: state unchanged, bound_err <= 1, FSM unchanged.
- Latency:
  - Outputs are registered; start -> state_valid=1 one cycle later.
  - dwell=D gives each state D+1 cycles of visibility.
- dwell=0: advance every cycle in RUN.
- Invariant: state is never outside MIN_STATE..MAX_STATE, under any input sequence including reset mid-dwell.
- Reset_n asserted mid-operation returns all outputs to their reset values immediately, asynchronously.

Decomposition:
- Shared package `seq_pkg`:
  - FSM state enum (IDLE, RUN, HOLD), 2-bit encoding.
  - Default MIN_STATE/MAX_STATE constants.
  - A `in_range` function used here and by the downstream decode assertions.
- One sub-module, `dwell_counter`:
  - DWELL_W-bit down-counter with reload and enable.
  - Outputs a `expire` pulse when it reaches 0.

Test Plan:
- Reset, start with dwell=0, dir=0: state 0,1,2..15,0 on consecutive cycles; wrap=1 only on the 15->0 cycle; state_valid=1 throughout.
- load_val=16 while RUN at state=7: state stays 7, bound_err=1 and stays 1; next start clears it.
- load_val=15 with dir=1, dwell=2: state=15 for 3 cycles, then 14. Separately, load 0 with dir=1: 0->15 with wrap=1.
- hold raised mid-dwell (dwell=3, after 2 cycles): state frozen for the whole hold; after release, 2 more cycles then advance.
- Same-cycle stop+load(5) in RUN: FSM -> IDLE, state=5, state_valid=0. Same-cycle load(9)+hold: state=9, FSM -> HOLD.
- Reset_n pulsed low mid-dwell at state=11: state=0 and state_valid=0 immediately; no advance until the next start.
